gray_sweep_source: RTL and testbench
====================================

Name: gray_sweep_source

Overview:
- Sequential stimulus source that produces the 4-bit Gray-code vectors consumed by the Gray-input decoder stage (G3..G0).
- Sits directly upstream of that decoder.
- Walks a programmable index range and converts each binary index to Gray, so consecutive outputs differ by exactly one bit.
- Delivers each code over a valid/ready handshake. The downstream decoder-plus-capture logic can stall it.

Parameters:
WIDTH, 4, code width in bits; index and Gray output width.
DONE_PULSE, 1, width of the done pulse in cycles. Fixed at 1; kept only for documentation.

Ports:
- clk  input  1  single system clock; all state changes on the rising edge.
- rst_n  input  1  reset, active-low, asynchronous assert, synchronous release.
- start  input  1  one-cycle request to begin a sweep. Ignored unless IDLE.
- stop  input  1  abort the current sweep.
- dir  input  1  1 = increment index, 0 = decrement. Sampled at start.
- wrap_en  input  1  1 = restart at first_idx after last_idx, until stop. Sampled at start.
- first_idx  input  WIDTH  first binary index. Sampled at start.
- last_idx  input  WIDTH  last binary index. Sampled at start.
- g_out  output  WIDTH  Gray code, g_out[3] = G3 … g_out[0] = G0.
- out_valid  output  1  g_out holds a valid code.
- out_ready  input  1  downstream accepts g_out this cycle.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse after the final non-wrapping transfer.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; idx=0.
  - Outputs: g_out=0, out_valid=0, busy=0, done=0.
  - Captured dir/wrap/first/last registers cleared.
- Conversion: g_out = idx ^ (idx >> 1). g_out is registered and always consistent with idx.
- A transfer occurs on a rising edge where out_valid && out_ready.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - out_valid=0, busy=0.
  - On start=1 (and stop=0): capture dir, wrap_en, first_idx, last_idx; set idx=first_idx; go to RUN.
  - out_valid rises on the cycle after start (latency 1).
  - start && stop together in IDLE: stop wins, stay IDLE.
- RUN:
  - out_valid=1, busy=1.
  - While out_valid && !out_ready: g_out and out_valid are held stable. No change allowed.
  - On transfer with idx != last: idx steps by ±1 modulo 2^WIDTH. Ranges may cross the 15/0 boundary in either direction.
  - On transfer with idx == last and wrap=1: idx=first, stay in RUN.
  - On transfer with idx == last and wrap=0: go to DONE; out_valid drops next cycle.
  - first == last with wrap=0 emits exactly one code.
  - stop=1 with no transfer: go to IDLE next cycle, out_valid=0. No done pulse.
  - stop=1 coincident with a transfer: the transfer counts, then go to IDLE. No done pulse, even if that was the last code.
  - start in RUN is ignored.
- DONE: done=1 for exactly one cycle, out_valid=0, busy=0; next state IDLE unconditionally. start in DONE is ignored.
- Throughput: with out_ready held 1, one code per cycle, no bubbles, including across wrap.
- Reset mid-sweep: immediate return to reset values. No partial code is presented after rst_n release.
- Sweep length (no wrap): ((last - first) mod 2^W) + 1 codes for dir=1; ((first - last) mod 2^W) + 1 codes for dir=0.

Decomposition:
- Shared package gray_pkg:
  - sweep_state_t enum {IDLE, RUN, DONE}.
  - localparam GRAY_W = 4.
  - Function bin2gray(logic [GRAY_W-1:0]).
- No sub-module needed. Conversion uses the package function; FSM and index counter live in one module. This keeps the block at roughly 150 lines.

Test Plan:
1. first=0, last=15, dir=1, wrap=0, out_ready=1, start pulse at cycle 0:
   - out_valid high cycles 1–16.
   - g_out = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000.
   - done=1 at cycle 17 only; each adjacent pair differs in one bit.
2. Backpressure: same sweep, out_ready=0 for cycles 3–6 → g_out holds 0011 and out_valid stays 1 through cycle 6; 0010 appears at cycle 8; total 16 transfers.
3. Down across boundary: first=3, last=14, dir=0, ready=1 → g_out 0010,0011,0001,0000,1000,1001, then done.
4. Wrap: first=1, last=2, wrap=1, ready=1 → 0001,0011,0001,0011,…; stop at cycle 6 → out_valid=0 at cycle 7, done never asserted.
5. Stop with handshake: assert stop on the cycle g_out=0110 is accepted → that transfer is counted, out_valid=0 next cycle, state IDLE, start in the same cycle as stop ignored.
6. Async reset: drop rst_n mid-sweep between edges → g_out=0000, out_valid=0, busy=0 immediately. After release, no output until a new start; first=last=5, wrap=0 → single code 0111, then done.

Source files
------------

// File: rtl/gray_pkg.sv
// Shared types and helpers for the Gray-code sweep source.
package gray_pkg;

  localparam int GRAY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sweep_state_t;

  // Binary to reflected-binary Gray conversion.
  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

endpackage

// File: rtl/gray_sweep_source.sv
// Gray-code stimulus source: walks a captured index range, presents each
// index as a Gray code over a valid/ready handshake, and optionally wraps.
module gray_sweep_source
  import gray_pkg::*;
#(
  parameter int WIDTH      = GRAY_W,
  parameter int DONE_PULSE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             dir,
  input  logic             wrap_en,
  input  logic [WIDTH-1:0] first_idx,
  input  logic [WIDTH-1:0] last_idx,
  output logic [WIDTH-1:0] g_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done
);

  sweep_state_t     state;
  logic [WIDTH-1:0] idx;
  logic [WIDTH-1:0] idx_step;
  logic             cap_dir;
  logic             cap_wrap;
  logic [WIDTH-1:0] cap_first;
  logic [WIDTH-1:0] cap_last;

  // Neighbouring index in the captured direction; wraps modulo 2^WIDTH.
  always_comb begin
    idx_step = cap_dir ? idx + WIDTH'(1) : idx - WIDTH'(1);
  end

  // Sweep FSM, index counter and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      g_out     <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      cap_dir   <= 1'b0;
      cap_wrap  <= 1'b0;
      cap_first <= '0;
      cap_last  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            cap_dir   <= dir;
            cap_wrap  <= wrap_en;
            cap_first <= first_idx;
            cap_last  <= last_idx;
            idx       <= first_idx;
            g_out     <= bin2gray(first_idx);
            out_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          if (stop) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (out_ready) begin
            if (idx == cap_last) begin
              if (cap_wrap) begin
                idx   <= cap_first;
                g_out <= bin2gray(cap_first);
              end else begin
                out_valid <= 1'b0;
                busy      <= 1'b0;
                done      <= (DONE_PULSE > 0);
                state     <= DONE;
              end
            end else begin
              idx   <= idx_step;
              g_out <= bin2gray(idx_step);
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_sweep_source.sv
// Randomized self-checking bench for gray_sweep_source with a sequence model.
module tb_gray_sweep_source;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       dir;
  logic       wrap_en;
  logic [3:0] first_idx;
  logic [3:0] last_idx;
  logic [3:0] g_out;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;
  logic [3:0] gray_tab [16];

  gray_sweep_source #(.WIDTH(4), .DONE_PULSE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .dir(dir),
    .wrap_en(wrap_en), .first_idx(first_idx), .last_idx(last_idx),
    .g_out(g_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reflect-and-prefix construction of the 4-bit Gray sequence.
  task automatic build_gray_tab();
    gray_tab[0] = 4'b0000;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < (1 << n); i++) begin
        gray_tab[(1 << n) + i] = gray_tab[(1 << n) - 1 - i] | 4'((1 << n));
      end
    end
  endtask

  function automatic logic ready_for(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 2) return !(cyc >= 3 && cyc <= 6);
    return ($urandom_range(0, 3) != 0);
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; start = 0; stop = 0; dir = 0; wrap_en = 0;
    first_idx = 0; last_idx = 0; out_ready = 0;
    #1;
    checks++;
    if ({g_out, out_valid, busy, done} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got g=%b v=%b b=%b d=%b expected all zero", g_out, out_valid, busy, done);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({g_out, out_valid, busy, done} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got g=%b v=%b b=%b d=%b expected all zero", g_out, out_valid, busy, done);
    end
  endtask

  // Non-wrapping sweep; mode 0 = ready high, 1 = random ready, 2 = stall cycles 3..6.
  task automatic run_sweep(input logic [3:0] f, input logic [3:0] l, input logic d, input int mode);
    int len, xfers, cyc;
    logic [3:0] e, prev_g;
    len = d ? (((int'(l) - int'(f)) & 15) + 1) : (((int'(f) - int'(l)) & 15) + 1);
    xfers = 0; cyc = 0; prev_g = 0;
    @(negedge clk);
    first_idx = f; last_idx = l; dir = d; wrap_en = 1'b0; start = 1'b1; stop = 1'b0;
    out_ready = ready_for(mode, 0);
    while (xfers < len && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        first_idx = 4'($urandom); last_idx = 4'($urandom);
        dir = 1'($urandom); wrap_en = 1'($urandom);
      end
      e = d ? f + 4'(xfers) : f - 4'(xfers);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL sweep_flags cyc=%0d: got v=%b b=%b d=%b expected v=1 b=1 d=0", cyc, out_valid, busy, done);
      end
      checks++;
      if (g_out !== gray_tab[e]) begin
        errors++;
        $display("[TB] FAIL sweep_code cyc=%0d: got %b expected %b", cyc, g_out, gray_tab[e]);
      end
      if (xfers > 0) begin
        checks++;
        if ($countones(g_out ^ prev_g) != 1) begin
          errors++;
          $display("[TB] FAIL one_bit_step cyc=%0d: got %b after %b expected one-bit change", cyc, g_out, prev_g);
        end
      end
      if (mode == 2 && cyc == 8) begin
        checks++;
        if (g_out !== 4'b0010) begin
          errors++;
          $display("[TB] FAIL stall_resume: got %b expected 0010 at cycle 8", g_out);
        end
      end
      out_ready = ready_for(mode, cyc);
      if (out_ready) begin
        xfers++;
        prev_g = gray_tab[e];
      end
    end
    if (cyc >= 300) begin
      errors++; checks++;
      $display("[TB] FAIL sweep_timeout: got %0d transfers expected %0d", xfers, len);
    end
    @(negedge clk);
    cyc++;
    out_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse cyc=%0d: got d=%b v=%b b=%b expected d=1 v=0 b=0", cyc, done, out_valid, busy);
    end
    if (mode == 0) begin
      checks++;
      if (cyc != len + 1) begin
        errors++;
        $display("[TB] FAIL done_cycle: got %0d expected %0d", cyc, len + 1);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_width: got d=%b v=%b expected d=0 v=0", done, out_valid);
    end
  endtask

  // Wrapping sweep, stopped (with ready asserted or not) at cycle stop_cyc.
  task automatic test_wrap(input logic [3:0] f, input logic [3:0] l, input logic d, input int stop_cyc, input int mode);
    logic [3:0] seq [$];
    int len, xfers;
    len = d ? (((int'(l) - int'(f)) & 15) + 1) : (((int'(f) - int'(l)) & 15) + 1);
    seq.delete();
    for (int k = 0; k < len; k++) seq.push_back(d ? f + 4'(k) : f - 4'(k));
    xfers = 0;
    @(negedge clk);
    first_idx = f; last_idx = l; dir = d; wrap_en = 1'b1; start = 1'b1; stop = 1'b0;
    out_ready = ready_for(mode, 0);
    for (int cyc = 1; cyc <= stop_cyc; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      wrap_en = 1'($urandom);
      checks++;
      if (out_valid !== 1'b1 || done !== 1'b0 || g_out !== gray_tab[seq[xfers % len]]) begin
        errors++;
        $display("[TB] FAIL wrap_code cyc=%0d: got g=%b v=%b d=%b expected g=%b v=1 d=0",
                 cyc, g_out, out_valid, done, gray_tab[seq[xfers % len]]);
      end
      out_ready = ready_for(mode, cyc);
      if (out_ready) xfers++;
    end
    stop = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stop = 1'b0;
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL wrap_stop k=%0d: got v=%b b=%b d=%b expected 0 0 0", k, out_valid, busy, done);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    @(negedge clk);
    first_idx = 4'd7; last_idx = 4'd9; dir = 1'b1; start = 1'b1; stop = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_stop_idle: got v=%b b=%b expected v=0 b=0", out_valid, busy);
    end
  endtask

  task automatic test_stop_handshake();
    int xfers, cyc;
    bit hit;
    xfers = 0; hit = 0;
    @(negedge clk);
    first_idx = 4'd0; last_idx = 4'd15; dir = 1'b1; wrap_en = 1'b0; start = 1'b1; out_ready = 1'b1;
    for (cyc = 1; cyc < 40 && !hit; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (out_valid && out_ready) xfers++;
      if (out_valid && g_out == 4'b0110) begin
        stop = 1'b1; start = 1'b1; hit = 1;
      end
    end
    checks++;
    if (!hit || xfers != 5) begin
      errors++;
      $display("[TB] FAIL stop_xfer_count: got %0d transfers (hit=%0d) expected 5", xfers, hit);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      stop = 1'b0; start = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stop_handshake k=%0d: got v=%b b=%b d=%b expected 0 0 0", k, out_valid, busy, done);
      end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    first_idx = 4'd2; last_idx = 4'd12; dir = 1'b1; wrap_en = 1'b0; start = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (g_out !== 4'b0000 || out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL async_reset: got g=%b v=%b b=%b d=%b expected 0000 0 0 0", g_out, out_valid, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("[TB] FAIL post_reset_idle k=%0d: got v=%b b=%b expected 0 0", k, out_valid, busy);
      end
    end
    run_sweep(4'd5, 4'd5, 1'($urandom), 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++) begin
      run_sweep(4'($urandom), 4'($urandom), 1'($urandom), 1);
    end
    for (int n = 0; n < 3; n++) begin
      test_wrap(4'($urandom), 4'($urandom), 1'($urandom), $urandom_range(5, 30), 1);
    end
  endtask

  initial begin
    build_gray_tab();
    test_reset();
    run_sweep(4'd0, 4'd15, 1'b1, 0);
    run_sweep(4'd0, 4'd15, 1'b1, 2);
    run_sweep(4'd3, 4'd14, 1'b0, 0);
    test_wrap(4'd1, 4'd2, 1'b1, 6, 0);
    test_start_stop_idle();
    test_stop_handshake();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
